// File: rtl/r_resp_wait_buffer.sv
// Out-of-order R response store keyed by uid {row,col}: 1-cycle store, 0-cycle combinational release, slot freed at next edge.
// Optional occupancy high-water mark on hwm when R_RESP_WAIT_BUFFER_HWM_EN is defined; otherwise hwm is tied to 0.
module r_resp_wait_buffer #(
  parameter int DEPTH      = 16,
  parameter int NUM_ROWS   = 16,
  parameter int NUM_COLS   = 16,
  parameter int UID_W      = $clog2(NUM_ROWS) + $clog2(NUM_COLS),
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int TAG_WIDTH  = 4,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [UID_W-1:0]      wr_uid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [RESP_WIDTH-1:0] wr_resp,
  input  logic                  wr_last,
  input  logic [TAG_WIDTH-1:0]  wr_tagid,
  input  logic                  rel_en,
  input  logic [UID_W-1:0]      rel_uid,
  output logic                  rel_hit,
  output logic [DATA_WIDTH-1:0] rel_data,
  output logic [RESP_WIDTH-1:0] rel_resp,
  output logic                  rel_last,
  output logic [TAG_WIDTH-1:0]  rel_tagid,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  input  logic                  err_clr,
  output logic                  err_ovf,
  output logic                  err_dup,
  output logic                  err_miss,
  output logic [CNT_W-1:0]      hwm
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [UID_W-1:0]      uid_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic [RESP_WIDTH-1:0] resp_q  [DEPTH];
  logic                  last_q  [DEPTH];
  logic [TAG_WIDTH-1:0]  tagid_q [DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             err_ovf_q, err_ovf_d, err_dup_q, err_dup_d, err_miss_q, err_miss_d;

  logic [DEPTH-1:0] wr_match, rel_match;
  logic             wr_dup, wr_accept, free_any;
  logic [IDX_W-1:0] free_idx;

  always_comb begin
    wr_match  = '0;
    rel_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_match[i]  = valid_q[i] && (uid_q[i] == wr_uid);
      rel_match[i] = rel_en && valid_q[i] && (uid_q[i] == rel_uid);
    end
  end

  // Lowest free slot, taken from the registered state so a slot released this cycle is not reused yet.
  always_comb begin
    free_idx = '0;
    free_any = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
        free_any = 1'b1;
      end
    end
  end

  assign wr_dup    = |wr_match;
  assign wr_accept = wr_en && !full_q && !wr_dup && free_any;
  assign rel_hit   = |rel_match;

  // At most one slot matches, so an AND-OR mux yields the payload or zero on a miss.
  always_comb begin
    rel_data  = '0;
    rel_resp  = '0;
    rel_last  = 1'b0;
    rel_tagid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel_data  = rel_data  | (data_q[i]  & {DATA_WIDTH{rel_match[i]}});
      rel_resp  = rel_resp  | (resp_q[i]  & {RESP_WIDTH{rel_match[i]}});
      rel_last  = rel_last  | (last_q[i]  & rel_match[i]);
      rel_tagid = rel_tagid | (tagid_q[i] & {TAG_WIDTH{rel_match[i]}});
    end
  end

  always_comb begin
    valid_d = valid_q & ~rel_match;
    if (wr_accept) valid_d[free_idx] = 1'b1;
    count_d    = count_q + CNT_W'(wr_accept) - CNT_W'(rel_hit);
    full_d     = (count_d == CNT_W'(DEPTH));
    empty_d    = (count_d == '0);
    err_ovf_d  = (err_clr ? 1'b0 : err_ovf_q)  | (wr_en && full_q);
    err_dup_d  = (err_clr ? 1'b0 : err_dup_q)  | (wr_en && wr_dup);
    err_miss_d = (err_clr ? 1'b0 : err_miss_q) | (rel_en && !rel_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      err_ovf_q  <= 1'b0;
      err_dup_q  <= 1'b0;
      err_miss_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      err_ovf_q  <= err_ovf_d;
      err_dup_q  <= err_dup_d;
      err_miss_q <= err_miss_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      uid_q[free_idx]   <= wr_uid;
      data_q[free_idx]  <= wr_data;
      resp_q[free_idx]  <= wr_resp;
      last_q[free_idx]  <= wr_last;
      tagid_q[free_idx] <= wr_tagid;
    end
  end

  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign err_ovf  = err_ovf_q;
  assign err_dup  = err_dup_q;
  assign err_miss = err_miss_q;

`ifdef R_RESP_WAIT_BUFFER_HWM_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (count_d > hwm_q) hwm_d = count_d;
    else if (err_clr)    hwm_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

endmodule

// File: tb/tb_r_resp_wait_buffer.sv
module tb_r_resp_wait_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rel_en, err_clr, wr_last;
  logic [7:0]  wr_uid, rel_uid;
  logic [63:0] wr_data;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_tagid;
  logic        rel_hit, rel_last, full, empty, err_ovf, err_dup, err_miss;
  logic [63:0] rel_data;
  logic [1:0]  rel_resp;
  logic [3:0]  rel_tagid;
  logic [4:0]  count, hwm;

  int checks   = 0;
  int failures = 0;

  r_resp_wait_buffer dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_uid(wr_uid), .wr_data(wr_data), .wr_resp(wr_resp),
    .wr_last(wr_last), .wr_tagid(wr_tagid),
    .rel_en(rel_en), .rel_uid(rel_uid), .rel_hit(rel_hit), .rel_data(rel_data),
    .rel_resp(rel_resp), .rel_last(rel_last), .rel_tagid(rel_tagid),
    .full(full), .empty(empty), .count(count),
    .err_clr(err_clr), .err_ovf(err_ovf), .err_dup(err_dup), .err_miss(err_miss),
    .hwm(hwm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  uid;
    logic [63:0] dat;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  tag;
  } ent_t;

  typedef struct {
    logic we; logic [7:0] wuid; logic [63:0] wdat; logic [1:0] wresp; logic wlast; logic [3:0] wtag;
    logic re; logic [7:0] ruid; logic clr;
    logic e_hit; logic [63:0] e_dat; logic [1:0] e_resp; logic e_last; logic [3:0] e_tag;
    logic [4:0] e_cnt; logic e_full; logic e_empty; logic e_ovf; logic e_dup; logic e_miss;
  } vec_t;

  vec_t vt[10];
  ent_t sb[$];
  ent_t e, n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic we, input logic [7:0] wu, input logic [63:0] wd, input logic [1:0] wr,
                     input logic wl, input logic [3:0] wt, input logic re, input logic [7:0] ru,
                     input logic clr);
    wr_en = we; wr_uid = wu; wr_data = wd; wr_resp = wr; wr_last = wl; wr_tagid = wt;
    rel_en = re; rel_uid = ru; err_clr = clr;
  endtask

  task automatic idle();
    drv(0, 8'h00, 64'h0, 2'd0, 1'b0, 4'h0, 0, 8'h00, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(input logic [7:0] uid);
    ent_t r;
    r.uid  = uid;
    r.dat  = {$urandom, $urandom};
    r.resp = 2'($urandom_range(0, 3));
    r.last = 1'($urandom_range(0, 1));
    r.tag  = 4'($urandom_range(0, 15));
    return r;
  endfunction

  task automatic chk_rel(input string nm, input ent_t x);
    chk({nm, " hit"}, 64'(rel_hit), 64'd1);
    chk({nm, " data"}, rel_data, x.dat);
    chk({nm, " resp"}, 64'(rel_resp), 64'(x.resp));
    chk({nm, " last"}, 64'(rel_last), 64'(x.last));
    chk({nm, " tag"}, 64'(rel_tagid), 64'(x.tag));
  endtask

  initial begin
    //       we wuid   wdat       wr wl wt   re ruid   clr hit dat       rs ls tg   cnt  fu em ov du mi
    vt[0] = '{1, 8'h12, 64'hA5A5, 0, 1, 3,   0, 8'h00, 0,  0, 64'h0,    0, 0, 0,   1,   0, 0, 0, 0, 0};
    vt[1] = '{0, 8'h00, 64'h0,    0, 0, 0,   1, 8'h12, 0,  1, 64'hA5A5, 0, 1, 3,   0,   0, 1, 0, 0, 0};
    vt[2] = '{1, 8'h21, 64'h1111, 2, 0, 1,   0, 8'h00, 0,  0, 64'h0,    0, 0, 0,   1,   0, 0, 0, 0, 0};
    vt[3] = '{1, 8'h21, 64'h2222, 1, 1, 7,   0, 8'h00, 0,  0, 64'h0,    0, 0, 0,   1,   0, 0, 0, 1, 0};
    vt[4] = '{0, 8'h00, 64'h0,    0, 0, 0,   1, 8'h21, 0,  1, 64'h1111, 2, 0, 1,   0,   0, 1, 0, 1, 0};
    vt[5] = '{0, 8'h00, 64'h0,    0, 0, 0,   0, 8'h00, 1,  0, 64'h0,    0, 0, 0,   0,   0, 1, 0, 0, 0};
    vt[6] = '{0, 8'h00, 64'h0,    0, 0, 0,   1, 8'h33, 0,  0, 64'h0,    0, 0, 0,   0,   0, 1, 0, 0, 1};
    vt[7] = '{1, 8'h50, 64'h5050, 3, 1, 9,   1, 8'h50, 1,  0, 64'h0,    0, 0, 0,   1,   0, 0, 0, 0, 1};
    vt[8] = '{0, 8'h00, 64'h0,    0, 0, 0,   1, 8'h50, 0,  1, 64'h5050, 3, 1, 9,   0,   0, 1, 0, 0, 1};
    vt[9] = '{0, 8'h00, 64'h0,    0, 0, 0,   0, 8'h00, 1,  0, 64'h0,    0, 0, 0,   0,   0, 1, 0, 0, 0};

    rst = 1'b1;
    idle();
    #12 rst = 1'b0;
    chk("reset count", 64'(count), 64'd0);
    chk("reset empty", 64'(empty), 64'd1);
    chk("reset full", 64'(full), 64'd0);
    chk("reset errs", 64'({err_ovf, err_dup, err_miss}), 64'd0);
    chk("reset hwm", 64'(hwm), 64'd0);
    tick();

    for (int i = 0; i < 10; i++) begin
      drv(vt[i].we, vt[i].wuid, vt[i].wdat, vt[i].wresp, vt[i].wlast, vt[i].wtag,
          vt[i].re, vt[i].ruid, vt[i].clr);
      #3;
      chk($sformatf("v%0d hit", i), 64'(rel_hit), 64'(vt[i].e_hit));
      chk($sformatf("v%0d data", i), rel_data, vt[i].e_dat);
      chk($sformatf("v%0d resp", i), 64'(rel_resp), 64'(vt[i].e_resp));
      chk($sformatf("v%0d last", i), 64'(rel_last), 64'(vt[i].e_last));
      chk($sformatf("v%0d tag", i), 64'(rel_tagid), 64'(vt[i].e_tag));
      tick();
      chk($sformatf("v%0d count", i), 64'(count), 64'(vt[i].e_cnt));
      chk($sformatf("v%0d full", i), 64'(full), 64'(vt[i].e_full));
      chk($sformatf("v%0d empty", i), 64'(empty), 64'(vt[i].e_empty));
      chk($sformatf("v%0d ovf", i), 64'(err_ovf), 64'(vt[i].e_ovf));
      chk($sformatf("v%0d dup", i), 64'(err_dup), 64'(vt[i].e_dup));
      chk($sformatf("v%0d miss", i), 64'(err_miss), 64'(vt[i].e_miss));
    end
    idle();

    // Fill to capacity, overflow, then simultaneous release+write while full
    for (int i = 0; i < 16; i++) begin
      e = mk(8'(i));
      drv(1, e.uid, e.dat, e.resp, e.last, e.tag, 0, 8'h00, 0);
      sb.push_back(e);
      tick();
    end
    idle();
    chk("fill full", 64'(full), 64'd1);
    chk("fill count", 64'(count), 64'd16);
    chk("fill empty", 64'(empty), 64'd0);
    n = mk(8'h40);
    drv(1, n.uid, n.dat, n.resp, n.last, n.tag, 0, 8'h00, 0);
    tick();
    chk("ovf flag", 64'(err_ovf), 64'd1);
    chk("ovf count", 64'(count), 64'd16);
    drv(0, 8'h00, 64'h0, 2'd0, 1'b0, 4'h0, 0, 8'h00, 1);
    tick();
    chk("ovf clr", 64'(err_ovf), 64'd0);

    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].uid == 8'h05) begin
        e = sb[i];
        sb.delete(i);
        break;
      end
    end
    drv(1, n.uid, n.dat, n.resp, n.last, n.tag, 1, 8'h05, 0);
    #3;
    chk_rel("simul rel05", e);
    tick();
    chk("simul count", 64'(count), 64'd15);
    chk("simul full", 64'(full), 64'd0);
    chk("simul ovf", 64'(err_ovf), 64'd1);
    drv(1, n.uid, n.dat, n.resp, n.last, n.tag, 0, 8'h00, 1);
    sb.push_back(n);
    tick();
    chk("refill count", 64'(count), 64'd16);
    chk("refill full", 64'(full), 64'd1);
    chk("refill ovf clr", 64'(err_ovf), 64'd0);

    while (sb.size() > 0) begin
      e = sb.pop_front();
      drv(0, 8'h00, 64'h0, 2'd0, 1'b0, 4'h0, 1, e.uid, 0);
      #3;
      chk_rel($sformatf("drain %0h", e.uid), e);
      tick();
    end
    drv(0, 8'h00, 64'h0, 2'd0, 1'b0, 4'h0, 0, 8'h00, 1);
    tick();
    idle();
    chk("drain count", 64'(count), 64'd0);
    chk("drain empty", 64'(empty), 64'd1);
    chk("drain errs", 64'({err_ovf, err_dup, err_miss}), 64'd0);
    chk("drain hwm", 64'(hwm), 64'd0);

    // Reset with 7 entries outstanding and a pending error
    for (int i = 0; i < 7; i++) begin
      e = mk(8'(8'h60 + i));
      drv(1, e.uid, e.dat, e.resp, e.last, e.tag, 0, 8'h00, 0);
      tick();
    end
    drv(0, 8'h00, 64'h0, 2'd0, 1'b0, 4'h0, 1, 8'h99, 0);
    tick();
    idle();
    chk("pre-rst count", 64'(count), 64'd7);
    chk("pre-rst miss", 64'(err_miss), 64'd1);
`ifdef R_RESP_WAIT_BUFFER_HWM_EN
    chk("pre-rst hwm", 64'(hwm), 64'd7);
`else
    chk("pre-rst hwm", 64'(hwm), 64'd0);
`endif
    #2 rst = 1'b1;
    #1;
    chk("rst count", 64'(count), 64'd0);
    chk("rst empty", 64'(empty), 64'd1);
    chk("rst errs", 64'({err_ovf, err_dup, err_miss}), 64'd0);
    chk("rst hwm", 64'(hwm), 64'd0);
    #1 rst = 1'b0;
    drv(0, 8'h00, 64'h0, 2'd0, 1'b0, 4'h0, 1, 8'h60, 0);
    #2;
    chk("post-rst hit", 64'(rel_hit), 64'd0);
    chk("post-rst data", rel_data, 64'h0);
    tick();
    chk("post-rst miss", 64'(err_miss), 64'd1);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/r_resp_wait_buffer.md
Name: r_resp_wait_buffer

Overview:
- Holding store for R-channel responses that arrive out of order. It sits directly downstream of the R ID ordering unit.
- Writes: the ordering unit writes a response keyed by its unique ID {row,col} when the response cannot be released yet.
- Releases: later the ordering unit presents that uid. The buffer returns the payload combinationally in the same cycle and frees the slot at the next clock edge.
- Status: reports full/empty/count so the ordering unit can block writes. Flags protocol errors.

Parameters:
- DEPTH, 16, number of response slots (max stored outstanding responses).
- NUM_ROWS, 16, original-ID rows of the uid space.
- NUM_COLS, 16, columns per row of the uid space.
- UID_W, $clog2(NUM_ROWS)+$clog2(NUM_COLS), unique-ID width {row,col}.
- DATA_WIDTH, 64, R data width.
- RESP_WIDTH, 2, R resp width.
- TAG_WIDTH, 4, tagid width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  store request
- wr_uid  in  UID_W  uid of response to store
- wr_data  in  DATA_WIDTH  payload data
- wr_resp  in  RESP_WIDTH  payload resp
- wr_last  in  1  payload last
- wr_tagid  in  TAG_WIDTH  payload tagid
- rel_en  in  1  release request
- rel_uid  in  UID_W  uid to release
- rel_hit  out  1  rel_uid matched a valid slot (combinational)
- rel_data  out  DATA_WIDTH  matched payload data; 0 on miss
- rel_resp  out  RESP_WIDTH  matched resp; 0 on miss
- rel_last  out  1  matched last; 0 on miss
- rel_tagid  out  TAG_WIDTH  matched tagid; 0 on miss
- full  out  1  count==DEPTH (registered)
- empty  out  1  count==0 (registered)
- count  out  CNT_W  valid slots
- err_clr  in  1  clear sticky error flags
- err_ovf  out  1  sticky: write while full
- err_dup  out  1  sticky: write of uid already stored
- err_miss  out  1  sticky: release with no match
- hwm  out  CNT_W  occupancy high-water mark (see optional feature)

Behaviour:
- Clock and reset: single clk. rst is asynchronous, active-high.
- Reset values: all slot valid bits 0, count=0, full=0, empty=1, err_ovf/err_dup/err_miss=0, hwm=0.
- Reset mid-operation: all stored entries are discarded with no flush.
- Per-slot state: valid, uid, data, resp, last, tagid.
- Write acceptance: a write is accepted when wr_en=1, full=0, and wr_uid matches no valid slot.
- Write slot: the lowest-index slot whose valid bit is 0 in the registered state. Entry is written and valid set at the posedge.
- Write visibility: a written entry is first visible to lookup the cycle after the write.
- Write while full: dropped; err_ovf<=1.
- Duplicate write: wr_uid matches a valid slot; write dropped, stored entry unchanged, err_dup<=1.
- Release lookup: combinational, gated by rel_en. rel_hit=1 when a valid slot's uid equals rel_uid; rel_* carry that slot's payload in the same cycle.
- Release miss or rel_en=0: rel_hit=0 and all rel_* outputs 0.
- Release free: on hit, the matching slot's valid bit clears at the posedge.
- Release miss error: rel_en=1 with no match sets err_miss<=1.
- Uniqueness: at most one slot can match, guaranteed by duplicate rejection. The lookup is a one-hot OR-mux.
- Simultaneous write and release:
  - Both take effect and count is unchanged.
  - The write slot is chosen from the pre-release state, so a slot freed this cycle is not reused until next cycle.
  - full is registered, so a write while full is dropped even if a release frees a slot in the same cycle.
  - A release of the uid being written in the same cycle is a miss.
- count update: count_next = count + accepted_write − release_hit, wrapping impossible by construction. full/empty are registered from count_next.
- Sticky errors: err_clr clears all flags at the posedge. A new error in the same cycle wins, and its flag is set.
- Latency: release data is 0 cycles from rel_en. Store is 1 cycle.

Optional Feature:
- Macro: R_RESP_WAIT_BUFFER_HWM_EN.
- Defined: hwm is a register that updates hwm<=count_next whenever count_next>hwm. It resets to 0 and is cleared by err_clr. If err_clr coincides with an update, it loads count_next.
- Undefined: no register is built and hwm is tied to 0.

Test Plan:
- Reset, then write uid 0x12 with data 0xA5A5, resp 0, last 1, tagid 3. Next cycle rel_en with uid 0x12 → same cycle rel_hit=1, rel_data=0xA5A5, rel_last=1, rel_tagid=3. Afterwards count 1→0, empty=1.
- Fill with 16 distinct uids → full=1, count=16. A 17th write → dropped, err_ovf=1, count stays 16. err_clr → err_ovf=0.
- Write uid 0x21, then write uid 0x21 again with different data → err_dup=1. Release 0x21 returns the first data, and count=0 after.
- Release uid 0x33 on an empty buffer → rel_hit=0, rel_data=0, err_miss=1, count 0.
- Full buffer, same cycle: release uid 0x05 and write uid 0x40 → write dropped, err_ovf=1, count=15, full=0. Next cycle write 0x40 → accepted into freed slot, count=16.
- Assert rst while count=7 → count=0, empty=1, all errors 0. Release of a previously stored uid → miss. With the macro: before reset, peak count 7 → hwm=7; after reset, hwm=0.
